pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/pipe_ctrl_pkg.sv | 30 +++
 rtl/pipe_ctrl_wdt.sv | 34 +++
 rtl/pipe_ctrl.sv | 152 +++++++++++++++
 tb/tb_pipe_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared defines (address bus, reset address, state encodings) and pipe_ctrl types.
// Interrupt support elsewhere is enabled by defining PIPE_CTRL_INT_EN.
`ifndef INST_ADDR_BUS
`define INST_ADDR_BUS 31:0
`endif
`ifndef RESET_ADDR
`define RESET_ADDR 32'h0000_0000
`endif
`ifndef ST_IDLE
`define ST_IDLE  2'd0
`define ST_STALL 2'd1
`define ST_FLUSH 2'd2
`endif

package pipe_ctrl_pkg;
   typedef enum logic [1:0] {
      IDLE  = `ST_IDLE,
      STALL = `ST_STALL,
      FLUSH = `ST_FLUSH
   } state_t;

   // Per-cycle decision shared by the next-state and output processes.
   typedef enum logic [2:0] {
      ACT_NONE,
      ACT_STALL,
      ACT_JUMP,
      ACT_INT,
      ACT_FLUSH
   } act_t;
endpackage

// File: rtl/pipe_ctrl_wdt.sv
// Stall watchdog: saturating count of consecutive stall cycles with a sticky timeout flag.
module pipe_ctrl_wdt #(
   parameter int WDT_LEN = 255
) (
   input  logic clk,
   input  logic rst_n,
   input  logic stall_req_i,
   output logic stall_timeout_o
);
   localparam logic [7:0] WDT_LIM = 8'(WDT_LEN);

   logic [7:0] cnt_reg, cnt_next;
   logic       to_reg, to_next;

   always_comb begin
      cnt_next = 8'd0;
      if (stall_req_i)
         cnt_next = (cnt_reg == 8'hFF) ? cnt_reg : cnt_reg + 8'd1;
      // Flag rises at the edge where the count reaches the limit.
      to_next = to_reg | (stall_req_i && (cnt_next == WDT_LIM));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_reg <= 8'd0;
         to_reg  <= 1'b0;
      end else begin
         cnt_reg <= cnt_next;
         to_reg  <= to_next;
      end
   end

   assign stall_timeout_o = to_reg;
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: stall, redirect/flush, pending jump and optional interrupt entry.
// Define PIPE_CTRL_INT_EN to enable the interrupt acceptance path.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int FLUSH_LEN = 2,
   parameter int WDT_LEN   = 255
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall_req_i,
   input  logic                  jump_flag_i,
   input  logic [`INST_ADDR_BUS] jump_addr_i,
   input  logic                  int_req_i,
   input  logic [`INST_ADDR_BUS] int_addr_i,
   input  logic [`INST_ADDR_BUS] ex_pc_i,
   output logic                  hold_pc_o,
   output logic                  hold_ir_o,
   output logic                  hold_idex_o,
   output logic                  jump_flag_o,
   output logic [`INST_ADDR_BUS] jump_addr_o,
   output logic                  int_ack_o,
   output logic [`INST_ADDR_BUS] epc_o,
   output logic                  stall_timeout_o
);
   localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_LEN - 1);

   state_t                state_reg, state_next;
   logic [2:0]            cnt_reg, cnt_next;
   logic                  pend_vld_reg, pend_vld_next;
   logic [`INST_ADDR_BUS] pend_addr_reg, pend_addr_next;
   logic [`INST_ADDR_BUS] jaddr_reg, jaddr_next;
   logic [`INST_ADDR_BUS] redir_addr;
   logic                  int_ok;
   act_t                  act;

`ifdef PIPE_CTRL_INT_EN
   logic [`INST_ADDR_BUS] epc_reg, epc_next;

   assign int_ok   = int_req_i && (state_reg == IDLE);
   assign epc_next = (act == ACT_INT) ? ex_pc_i : epc_reg;
   assign epc_o    = epc_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) epc_reg <= `RESET_ADDR;
      else        epc_reg <= epc_next;
   end
`else
   logic unused_int_in;

   assign unused_int_in = ^{int_req_i, int_addr_i, ex_pc_i};
   assign int_ok        = 1'b0;
   assign epc_o         = `RESET_ADDR;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= IDLE;
         cnt_reg       <= 3'd0;
         pend_vld_reg  <= 1'b0;
         pend_addr_reg <= `RESET_ADDR;
         jaddr_reg     <= `RESET_ADDR;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         pend_vld_reg  <= pend_vld_next;
         pend_addr_reg <= pend_addr_next;
         jaddr_reg     <= jaddr_next;
      end
   end

   // Priority: stall > pending jump > live jump > interrupt > flush countdown.
   always_comb begin
      state_next     = state_reg;
      cnt_next       = cnt_reg;
      pend_vld_next  = pend_vld_reg;
      pend_addr_next = pend_addr_reg;
      redir_addr     = jaddr_reg;
      act            = ACT_NONE;
      if (stall_req_i) begin
         act        = ACT_STALL;
         state_next = STALL;
         if (jump_flag_i) begin
            pend_vld_next  = 1'b1;
            pend_addr_next = jump_addr_i;
         end
      end else if (pend_vld_reg) begin
         act           = ACT_JUMP;
         redir_addr    = pend_addr_reg;
         pend_vld_next = 1'b0;
      end else if (jump_flag_i) begin
         act        = ACT_JUMP;
         redir_addr = jump_addr_i;
      end else if (int_ok) begin
         act        = ACT_INT;
         redir_addr = int_addr_i;
      end else if (state_reg != IDLE && cnt_reg != 3'd0) begin
         // Also resumes a flush that a stall interrupted.
         act        = ACT_FLUSH;
         cnt_next   = cnt_reg - 3'd1;
         state_next = (cnt_reg == 3'd1) ? IDLE : FLUSH;
      end else begin
         state_next = IDLE;
      end
      if (act == ACT_JUMP || act == ACT_INT) begin
         cnt_next   = FLUSH_LOAD;
         state_next = (FLUSH_LEN == 1) ? IDLE : FLUSH;
      end
      jaddr_next = (act == ACT_JUMP || act == ACT_INT) ? redir_addr : jaddr_reg;
   end

   always_comb begin
      hold_pc_o   = 1'b0;
      hold_ir_o   = 1'b0;
      hold_idex_o = 1'b0;
      jump_flag_o = 1'b0;
      int_ack_o   = 1'b0;
      jump_addr_o = jaddr_reg;
      if (rst_n) begin
         case (act)
            ACT_STALL: begin
               hold_pc_o   = 1'b1;
               hold_ir_o   = 1'b1;
               hold_idex_o = 1'b1;
            end
            ACT_JUMP, ACT_INT: begin
               hold_ir_o   = 1'b1;
               hold_idex_o = 1'b1;
               jump_flag_o = 1'b1;
               jump_addr_o = redir_addr;
`ifdef PIPE_CTRL_INT_EN
               int_ack_o   = (act == ACT_INT);
`endif
            end
            ACT_FLUSH: begin
               hold_ir_o   = 1'b1;
               hold_idex_o = 1'b1;
            end
            default: ;
         endcase
      end
   end

   pipe_ctrl_wdt #(
      .WDT_LEN(WDT_LEN)
   ) u_wdt (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall_req_i    (stall_req_i),
      .stall_timeout_o(stall_timeout_o)
   );
endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus queues expected outputs, a negedge monitor compares.
// Interrupt expectations follow PIPE_CTRL_INT_EN.
module tb_pipe_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        stall_req_i = 1'b0, jump_flag_i = 1'b0, int_req_i = 1'b0;
   logic [31:0] jump_addr_i = '0, int_addr_i = '0, ex_pc_i = '0;
   logic        hold_pc_o, hold_ir_o, hold_idex_o, jump_flag_o, int_ack_o, stall_timeout_o;
   logic [31:0] jump_addr_o, epc_o;

   typedef struct {
      string       name;
      logic [69:0] v;
   } exp_t;

   exp_t        q[$];
   exp_t        mon_e;
   logic [69:0] act_v;
   int          checks = 0;
   int          passed = 0;
   logic [31:0] la, epc_x;

   pipe_ctrl dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall_req_i    (stall_req_i),
      .jump_flag_i    (jump_flag_i),
      .jump_addr_i    (jump_addr_i),
      .int_req_i      (int_req_i),
      .int_addr_i     (int_addr_i),
      .ex_pc_i        (ex_pc_i),
      .hold_pc_o      (hold_pc_o),
      .hold_ir_o      (hold_ir_o),
      .hold_idex_o    (hold_idex_o),
      .jump_flag_o    (jump_flag_o),
      .jump_addr_o    (jump_addr_o),
      .int_ack_o      (int_ack_o),
      .epc_o          (epc_o),
      .stall_timeout_o(stall_timeout_o)
   );

   always #5 clk = ~clk;

   // Vector layout: {hold_pc, hold_ir, hold_idex, jump_flag, jump_addr, int_ack, epc, timeout}
   always @(negedge clk) begin
      if (q.size() != 0) begin
         mon_e = q.pop_front();
         act_v = {hold_pc_o, hold_ir_o, hold_idex_o, jump_flag_o, jump_addr_o,
                  int_ack_o, epc_o, stall_timeout_o};
         checks++;
         if (act_v === mon_e.v) begin
            passed++;
            $display("txn %s ok: %h", mon_e.name, act_v);
         end else begin
            $display("FAIL %s: got %h expected %h", mon_e.name, act_v, mon_e.v);
         end
      end
   end

   task automatic drive(input logic st, input logic jf, input logic [31:0] ja,
                        input logic ir, input logic [31:0] ia, input logic [31:0] pc);
      stall_req_i = st;
      jump_flag_i = jf;
      jump_addr_i = ja;
      int_req_i   = ir;
      int_addr_i  = ia;
      ex_pc_i     = pc;
   endtask

   task automatic expect_out(input string nm, input logic [2:0] h, input logic jf,
                             input logic [31:0] ja, input logic ack,
                             input logic [31:0] epc, input logic to);
      exp_t e;
      e.name = nm;
      e.v    = {h, jf, ja, ack, epc, to};
      q.push_back(e);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      tick;
      expect_out("reset", 3'b000, 0, 32'h0, 0, 32'h0, 0);
      tick;
      rst_n = 1'b1;
      epc_x = 32'h0;

      // Single-cycle jump, two flush cycles, back to idle
      drive(0, 1, 32'h100, 0, 0, 0);
      expect_out("jump_c0", 3'b011, 1, 32'h100, 0, epc_x, 0); tick;
      drive(0, 0, 0, 0, 0, 0);
      expect_out("jump_c1", 3'b011, 0, 32'h100, 0, epc_x, 0); tick;
      expect_out("jump_idle", 3'b000, 0, 32'h100, 0, epc_x, 0); tick;

      // Jump arriving during a stall is deferred until the stall drops
      drive(1, 0, 0, 0, 0, 0);
      expect_out("stall_c1", 3'b111, 0, 32'h100, 0, epc_x, 0); tick;
      drive(1, 1, 32'h200, 0, 0, 0);
      expect_out("stall_c2", 3'b111, 0, 32'h100, 0, epc_x, 0); tick;
      drive(1, 0, 0, 0, 0, 0);
      expect_out("stall_c3", 3'b111, 0, 32'h100, 0, epc_x, 0); tick;
      drive(0, 0, 0, 0, 0, 0);
      expect_out("pend_c4", 3'b011, 1, 32'h200, 0, epc_x, 0); tick;
      expect_out("pend_c5", 3'b011, 0, 32'h200, 0, epc_x, 0); tick;
      expect_out("pend_idle", 3'b000, 0, 32'h200, 0, epc_x, 0); tick;

      // Stall during flush pauses the countdown
      drive(0, 1, 32'h300, 0, 0, 0);
      expect_out("fp_jump", 3'b011, 1, 32'h300, 0, epc_x, 0); tick;
      drive(1, 0, 0, 0, 0, 0);
      expect_out("fp_st1", 3'b111, 0, 32'h300, 0, epc_x, 0); tick;
      expect_out("fp_st2", 3'b111, 0, 32'h300, 0, epc_x, 0); tick;
      drive(0, 0, 0, 0, 0, 0);
      expect_out("fp_resume", 3'b011, 0, 32'h300, 0, epc_x, 0); tick;
      expect_out("fp_idle", 3'b000, 0, 32'h300, 0, epc_x, 0); tick;

      // Jump during flush redirects again and reloads
      drive(0, 1, 32'h400, 0, 0, 0);
      expect_out("jf_c0", 3'b011, 1, 32'h400, 0, epc_x, 0); tick;
      drive(0, 1, 32'h440, 0, 0, 0);
      expect_out("jf_re", 3'b011, 1, 32'h440, 0, epc_x, 0); tick;
      drive(0, 0, 0, 0, 0, 0);
      expect_out("jf_c2", 3'b011, 0, 32'h440, 0, epc_x, 0); tick;
      expect_out("jf_idle", 3'b000, 0, 32'h440, 0, epc_x, 0); tick;

`ifdef PIPE_CTRL_INT_EN
      drive(0, 0, 0, 1, 32'h80, 32'h44);
      expect_out("int_acc", 3'b011, 1, 32'h80, 1, 32'h0, 0); tick;
      drive(0, 0, 0, 0, 32'h80, 32'h44);
      expect_out("int_flush", 3'b011, 0, 32'h80, 0, 32'h44, 0); tick;
      expect_out("int_idle", 3'b000, 0, 32'h80, 0, 32'h44, 0); tick;
      drive(0, 1, 32'h500, 1, 32'h80, 32'h48);
      expect_out("int_vs_jump", 3'b011, 1, 32'h500, 0, 32'h44, 0); tick;
      drive(0, 0, 0, 1, 32'h90, 32'h48);
      expect_out("int_in_flush", 3'b011, 0, 32'h500, 0, 32'h44, 0); tick;
      drive(0, 0, 0, 0, 0, 0);
      expect_out("int_done", 3'b000, 0, 32'h500, 0, 32'h44, 0); tick;
      la    = 32'h500;
      epc_x = 32'h44;
`else
      drive(0, 0, 0, 1, 32'h80, 32'h44);
      expect_out("noint_c0", 3'b000, 0, 32'h440, 0, 32'h0, 0); tick;
      expect_out("noint_c1", 3'b000, 0, 32'h440, 0, 32'h0, 0); tick;
      drive(0, 0, 0, 0, 0, 0);
      expect_out("noint_idle", 3'b000, 0, 32'h440, 0, 32'h0, 0); tick;
      la = 32'h440;
`endif

      // Watchdog: flag rises after the 255th consecutive stall cycle and sticks
      drive(1, 0, 0, 0, 0, 0);
      for (int i = 1; i <= 256; i++) begin
         if (i == 255) expect_out("wdt_c255", 3'b111, 0, la, 0, epc_x, 0);
         if (i == 256) expect_out("wdt_c256", 3'b111, 0, la, 0, epc_x, 1);
         tick;
      end
      drive(0, 0, 0, 0, 0, 0);
      expect_out("wdt_sticky0", 3'b000, 0, la, 0, epc_x, 1); tick;
      expect_out("wdt_sticky1", 3'b000, 0, la, 0, epc_x, 1); tick;

      // Asynchronous reset mid-flush with a jump pending
      drive(0, 1, 32'h600, 0, 0, 0);
      expect_out("rst_pre_jump", 3'b011, 1, 32'h600, 0, epc_x, 1); tick;
      drive(1, 1, 32'h700, 0, 0, 0);
      expect_out("rst_pre_pend", 3'b111, 0, 32'h600, 0, epc_x, 1); tick;
      drive(1, 0, 0, 0, 0, 0);
      rst_n = 1'b0;
      expect_out("rst_async", 3'b000, 0, 32'h0, 0, 32'h0, 0); tick;
      rst_n = 1'b1;
      drive(0, 0, 0, 0, 0, 0);
      expect_out("rst_no_redir0", 3'b000, 0, 32'h0, 0, 32'h0, 0); tick;
      expect_out("rst_no_redir1", 3'b000, 0, 32'h0, 0, 32'h0, 0); tick;

      @(negedge clk);
      #1;
      checks++;
      if (q.size() == 0) passed++;
      else $display("FAIL queue_drain: got %0d entries left expected 0", q.size());

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
